obj_scan_sched: RTL
===================

# obj_scan_sched

Time-multiplexed scheduler for the game's object-detection datapath. One shared checker (block-touch, freeze or pickup test) replaces per-object replicated instances. On each frame `start`, the scheduler walks object indices `0..OBJ_NUM-1` into the checker through a valid/ready handshake and collects in-order hit results. When the scan completes it publishes a frame-consistent hit bitmap to `game_state`, `score_count` and the `*_show` renderers. It sits between the frame-tick source and the coordinate tables and checker.

## Interface
- `OBJ_NUM`, 50: number of objects scanned per frame (2..1023).
- `IDX_W`, localparam `$clog2(OBJ_NUM)`: index width.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle scan request, typically once per frame at vertical sync.
- `clear`  in  1  synchronous clear of maps and flags; aborts any scan in progress.
- `obj_valid`  out  1  index presented to the checker.
- `obj_idx`  out  IDX_W  object index; indexes the coordinate tables.
- `obj_ready`  in  1  checker accepts `obj_idx` on this edge when `obj_valid`=1.
- `hit_valid`  in  1  checker result strobe; results return in issue order.
- `hit_in`  in  1  result for the oldest outstanding index.
- `hit_map`  out  OBJ_NUM  published per-object hit bits.
- `hit_count`  out  IDX_W+1  population count of `hit_map`.
- `any_hit`  out  1  OR of `hit_map`.
- `busy`  out  1  FSM not in IDLE.
- `done`  out  1  one-cycle pulse on the cycle `hit_map` is updated.
- `overrun`  out  1  sticky: `start` arrived while `busy`.

## Operation
- The FSM has four states: IDLE, ISSUE, DRAIN, FLUSH.
- IDLE, `start`=1 and `clear`=0: go to ISSUE. Clear `issue_idx`, `ret_idx`, the shadow map and the outstanding counter.
- ISSUE: `obj_valid`=1 and `obj_idx`=`issue_idx`. On `obj_ready`, increment `issue_idx`. On the handshake with `issue_idx`=OBJ_NUM-1, go to DRAIN.
- DRAIN: `obj_valid`=0. Wait until `ret_idx`=OBJ_NUM, then return to IDLE.
- On the edge entering IDLE from DRAIN, drive `done`=1 and update `hit_map`.
- Result capture happens in ISSUE and DRAIN. Each `hit_valid` writes `shadow[ret_idx]`<=`hit_in` and increments `ret_idx`.
- The outstanding counter tracks issued minus returned. It increments on each handshake, decrements on each `hit_valid`, and holds when both occur in the same cycle.
- `hit_valid` in IDLE: ignored. No state change.
- `hit_valid` while `ret_idx`=OBJ_NUM: ignored.
- `clear` in ISSUE or DRAIN: abort with no `done` and no map update. Go to FLUSH if outstanding ≠ 0, otherwise go to IDLE.
- FLUSH: `obj_valid`=0. Discard `hit_valid` and decrement outstanding on each one. Go to IDLE when the count reaches 0. `start` is ignored in FLUSH and does not set `overrun`.
- `clear` in any state: `hit_map`<=0, shadow<=0, `overrun`<=0.
- `start` and `clear` in the same cycle: `clear` wins and `start` is dropped.
- `start` in ISSUE or DRAIN: ignored, sets `overrun`<=1.
- `hit_count` and `any_hit` are registered. They are computed from the next value of `hit_map`, so they update on the same edge as `hit_map`.
- `obj_idx` holds its value while `obj_ready`=0. It never exceeds OBJ_NUM-1.

## Timing
- Reset values: state IDLE, `obj_valid`=0, `obj_idx`=0, `hit_map`=0, `hit_count`=0, `any_hit`=0, `busy`=0, `done`=0, `overrun`=0, all counters 0.
- Reset mid-scan: all outputs return to these values immediately, with no `done`.
- `start` sampled at edge T: `busy`=1 and `obj_valid`=1 with `obj_idx`=0 from T+1.
- With `obj_ready` held high, the last index issues at T+OBJ_NUM.
- With checker latency L (result k returns L cycles after issue k), the last result is captured at T+OBJ_NUM+L. At the following edge, `done`=1, `busy`=0, and `hit_map`, `hit_count` and `any_hit` all become valid together.
- A `start` in the cycle `done` is high is accepted, since the FSM is already in IDLE.
- Back-to-back frames are therefore possible at a period of OBJ_NUM+L+1 cycles.

## Configuration
- `SCAN_STICKY_EN` defined: at `done`, `hit_map`<=`hit_map`|shadow. Bits accumulate across frames, so iced blocks stay iced. Only `clear` or `reset` zeroes them.
- `SCAN_STICKY_EN` undefined: at `done`, `hit_map`<=shadow. Each frame replaces the map.

## Test plan
- OBJ_NUM=50, L=2, `obj_ready`=1, checker returns 1 for indices 3 and 49 -> `done` at T+53, `hit_map`=bits 3 and 49, `hit_count`=2, `any_hit`=1.
- `obj_ready` toggling 1/0 each cycle -> each index 0..49 is issued exactly once, `obj_idx` holds while `obj_ready`=0, `done` at T+100+L+1, map identical to the ready-high run.
- `start` asserted at T+10 during a scan -> `overrun`=1, scan unaffected, a single `done`; a subsequent `clear` drops `overrun` to 0.
- `clear` at T+20 with 2 results outstanding -> FSM passes through FLUSH for 2 `hit_valid`, no `done`, `hit_map`=0, and a `start` during FLUSH is ignored.
- Frame 1 hits {5}, frame 2 hits {7} -> with `SCAN_STICKY_EN`, `hit_map`={5,7} and `hit_count`=2; without it, `hit_map`={7} and `hit_count`=1.
- `reset` pulsed at T+30 mid-scan -> all outputs return to reset values immediately, no `done`; a new `start` yields a correct full scan.

Source files
------------

// File: rtl/obj_scan_sched.sv
// Time-multiplexed object scan scheduler: walks object indices through one shared checker and publishes a frame hit map.
// Optional feature macro: SCAN_STICKY_EN (accumulate hit bits across frames instead of replacing them).
module obj_scan_sched #(
  parameter int OBJ_NUM = 50,
  localparam int IDX_W = $clog2(OBJ_NUM)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               clear,
  output logic               obj_valid,
  output logic [IDX_W-1:0]   obj_idx,
  input  logic               obj_ready,
  input  logic               hit_valid,
  input  logic               hit_in,
  output logic [OBJ_NUM-1:0] hit_map,
  output logic [IDX_W:0]     hit_count,
  output logic               any_hit,
  output logic               busy,
  output logic               done,
  output logic               overrun
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FLUSH} state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     issue_idx;
  logic [IDX_W:0]       ret_idx, outstanding, out_nxt, count_nxt;
  logic [OBJ_NUM-1:0]   shadow, map_nxt;
  logic                 handshake, hv_take, last_issue, ret_full, scan_start, scan_done;

  // Handshake: an index transfers on a rising edge where obj_valid and obj_ready are both high;
  // obj_valid never drops and obj_idx never changes until that transfer. Results return in issue order.
  assign handshake  = obj_valid && obj_ready;
  assign last_issue = handshake && (issue_idx == IDX_W'(OBJ_NUM - 1));
  assign ret_full   = (ret_idx == (IDX_W+1)'(OBJ_NUM));
  assign scan_start = (state == IDLE) && start && !clear;
  assign scan_done  = (state == DRAIN) && ret_full && !clear;
  assign obj_idx    = issue_idx;

  always_comb begin
    hv_take = 1'b0;
    case (state)
      ISSUE, DRAIN: hv_take = hit_valid && !ret_full;
      FLUSH:        hv_take = hit_valid && (outstanding != '0);
      default:      hv_take = 1'b0;
    endcase
  end

  // A transfer on the clearing edge is already owned by the checker, so it still counts as outstanding.
  assign out_nxt = outstanding + (IDX_W+1)'(handshake) - (IDX_W+1)'(hv_take);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (scan_start) state_nxt = ISSUE;
      ISSUE: begin
        if (clear)           state_nxt = (out_nxt != '0) ? FLUSH : IDLE;
        else if (last_issue) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (clear)           state_nxt = (out_nxt != '0) ? FLUSH : IDLE;
        else if (ret_full)   state_nxt = IDLE;
      end
      FLUSH: if (out_nxt == '0) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  always_comb begin
    obj_valid = (state == ISSUE);
    busy      = (state != IDLE);
  end

  always_comb begin
    map_nxt = hit_map;
    if (clear) begin
      map_nxt = '0;
    end else if (scan_done) begin
`ifdef SCAN_STICKY_EN
      map_nxt = hit_map | shadow;
`else
      map_nxt = shadow;
`endif
    end
    count_nxt = '0;
    for (int i = 0; i < OBJ_NUM; i++) count_nxt = count_nxt + (IDX_W+1)'(map_nxt[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_idx   <= '0;
      ret_idx     <= '0;
      outstanding <= '0;
      shadow      <= '0;
      hit_map     <= '0;
      hit_count   <= '0;
      any_hit     <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      done <= scan_done;
      if (scan_start) begin
        issue_idx   <= '0;
        ret_idx     <= '0;
        outstanding <= '0;
        shadow      <= '0;
      end else begin
        if (handshake && !last_issue) issue_idx <= issue_idx + IDX_W'(1);
        outstanding <= out_nxt;
        if (hv_take && (state != FLUSH)) begin
          shadow[ret_idx[IDX_W-1:0]] <= hit_in;
          ret_idx                    <= ret_idx + (IDX_W+1)'(1);
        end
      end
      if (clear) shadow <= '0;
      hit_map   <= map_nxt;
      hit_count <= count_nxt;
      any_hit   <= |map_nxt;
      if (clear)
        overrun <= 1'b0;
      else if (start && ((state == ISSUE) || (state == DRAIN)))
        overrun <= 1'b1;
    end
  end

endmodule
